cfg_regfile_mp: RTL and testbench

- Parametrised multi-read-port configuration register file; successor to the single-read dual-port config regfile.
- Adds the following over the previous generation:
  - NRD independent read ports.
  - Byte-lane write strobes.
  - Selectable read latency.
  - Read-during-write bypass.
  - Sequential clear engine, replacing the one-cycle full-array reset. The clear engine also runs on software request.
- Sits between the interface controller (write side) and the protocol engines (read side).

---
 rtl/cfg_regfile_mp.sv | 154 +++++++++++++++
 tb/tb_cfg_regfile_mp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_regfile_mp.sv
// Multi-read-port configuration register file with byte strobes, a sequential
// clear engine, optional read-during-write bypass and a 1- or 2-cycle read pipe.

module cfg_regfile_rdport #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               idle,
  input  logic               rd_en,
  input  logic               wr_hit,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [WIDTH-1:0]   mem_word,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   data_out
);
  logic [WIDTH-1:0]             rd_word;
  logic [RD_LAT:1]              vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1][WIDTH-1:0]   dat_pipe_q, dat_pipe_d;

  // Strobed lanes of a colliding write are forwarded; the rest come from the array.
  always_comb begin
    rd_word = mem_word;
    for (int k = 0; k < WIDTH/8; k++)
      if (BYPASS != 0 && wr_hit && wr_be[k]) rd_word[8*k +: 8] = data_in[8*k +: 8];
  end

  // Anything still in flight when the clear engine starts is dropped.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = idle & rd_en;
    if (vld_pipe_d[1]) dat_pipe_d[1] = rd_word;
    for (int s = 2; s <= RD_LAT; s++) begin
      vld_pipe_d[s] = idle & vld_pipe_q[s-1];
      if (vld_pipe_d[s]) dat_pipe_d[s] = dat_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign rd_valid = vld_pipe_q[RD_LAT];
  assign data_out = dat_pipe_q[RD_LAT];
endmodule

module cfg_regfile_mp #(
  parameter int WIDTH  = 8,
  parameter int ADDR   = 15,
  parameter int NRD    = 2,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req,
  output logic                 busy,
  input  logic                 wr_en,
  input  logic [ADDR-1:0]      wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*ADDR-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0] data_out,
  output logic [NRD-1:0]       rd_valid
);
  localparam int NB    = WIDTH/8;
  localparam int DEPTH = 2**ADDR;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR-1:0]   ptr_q, ptr_d;
  logic              mem_we;
  logic [ADDR-1:0]   mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [NB-1:0]     mem_wbe;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              idle;

  // The clear engine and the host share the single array write port.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = data_in;
    mem_wbe   = wr_be;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        mem_we = wr_en;
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we)
      for (int k = 0; k < NB; k++)
        if (mem_wbe[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
  end

  assign idle = (state_q == IDLE);
  assign busy = ~idle;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR-1:0] ra;
    assign ra = rd_addr[p*ADDR +: ADDR];
    cfg_regfile_rdport #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .BYPASS(BYPASS)) u_port (
      .clk      (clk),
      .reset    (reset),
      .idle     (idle),
      .rd_en    (rd_en[p]),
      .wr_hit   (idle & wr_en & (wr_addr == ra)),
      .wr_be    (wr_be),
      .data_in  (data_in),
      .mem_word (mem[ra]),
      .rd_valid (rd_valid[p]),
      .data_out (data_out[p*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_cfg_regfile_mp.sv
// Bench for cfg_regfile_mp: two configurations share one stimulus stream and
// are compared every cycle against an array/queue-level model.
module tb_cfg_regfile_mp;
  logic        clk = 1'b0;
  logic        reset, clr_req, wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] data_in;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        busy1, busy2;
  logic [31:0] dout1, dout2;
  logic [1:0]  vld1, vld2;

  always #5 clk = ~clk;

  cfg_regfile_mp #(.WIDTH(16), .ADDR(4), .NRD(2), .RD_LAT(1), .BYPASS(1)) u1 (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy1), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(dout1), .rd_valid(vld1));

  cfg_regfile_mp #(.WIDTH(16), .ADDR(4), .NRD(2), .RD_LAT(2), .BYPASS(0)) u2 (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy2), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(dout2), .rd_valid(vld2));

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // Reference model: memory array plus "clear cycles remaining" counter.
  // A clear (or reset) zeroes the whole array at once; reads are ignored while
  // the counter is nonzero, so the sweep order is not observable.
  logic [15:0] m [16];
  int          clr_left;
  logic [1:0]  v1, v2, pv2;
  logic [15:0] d1 [2], d2 [2], pd2 [2];

  always @(posedge clk) begin : model
    logic [3:0]  a;
    logic [15:0] old, mk;
    mk = lane_mask(wr_be);
    if (!reset) begin
      foreach (m[i]) m[i] = '0;
      clr_left = 16;
      v1 = '0; v2 = '0; pv2 = '0;
      for (int p = 0; p < 2; p++) begin d1[p] = '0; d2[p] = '0; pd2[p] = '0; end
    end else if (clr_left > 0) begin
      clr_left--;
      v1 = '0; v2 = '0; pv2 = '0;
    end else begin
      v2 = pv2;
      for (int p = 0; p < 2; p++) if (pv2[p]) d2[p] = pd2[p];
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          a      = rd_addr[p*4 +: 4];
          old    = m[a];
          v1[p]  = 1'b1;
          pv2[p] = 1'b1;
          pd2[p] = old;
          d1[p]  = (wr_en && wr_addr == a) ? ((old & ~mk) | (data_in & mk)) : old;
        end else begin
          v1[p]  = 1'b0;
          pv2[p] = 1'b0;
        end
      end
      if (wr_en) m[wr_addr] = (m[wr_addr] & ~mk) | (data_in & mk);
      if (clr_req) begin
        clr_left = 16;
        foreach (m[i]) m[i] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy1", {31'd0, busy1}, {31'd0, clr_left > 0});
      check("busy2", {31'd0, busy2}, {31'd0, clr_left > 0});
      check("vld1",  {30'd0, vld1},  {30'd0, v1});
      check("vld2",  {30'd0, vld2},  {30'd0, v2});
      check("dout1", dout1, {d1[1], d1[0]});
      check("dout2", dout2, {d2[1], d2[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; data_in = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rd_en   = 2'b11;
      rd_addr = {4'(15 - i), 4'(i)};
      tick();
    end
    rd_en = 2'b00;
    tick();
    tick();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic rd0(input logic [3:0] a, input logic [15:0] e1, input logic [15:0] e2, input string nm);
    rd_en = 2'b01; rd_addr[3:0] = a;
    tick();
    rd_en = 2'b00;
    check({nm, "_lat1"}, {16'd0, dout1[15:0]}, {16'd0, e1});
    check({nm, "_vld1"}, {30'd0, vld1}, 32'd1);
    tick();
    check({nm, "_lat2"}, {16'd0, dout2[15:0]}, {16'd0, e2});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, vc;
    reset = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0;
    data_in = '0; rd_en = '0; rd_addr = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy1}, 32'd1);
    check("rst_vld",  {28'd0, vld1, vld2}, 32'd0);
    check("rst_dout1", dout1, 32'd0);
    check("rst_dout2", dout2, 32'd0);

    reset = 1'b1;
    wait_clear(n);
    check("clr_len_reset", n, 16);
    read_all();
    rd0(4'd5, 16'h0000, 16'h0000, "init_a5");

    wr(4'd3, 16'hA5C3, 2'b01);
    rd0(4'd3, 16'h00C3, 16'h00C3, "be_lo");
    wr(4'd3, 16'h1234, 2'b10);
    rd0(4'd3, 16'h12C3, 16'h12C3, "be_hi");

    wr(4'd7, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd7; data_in = 16'hBEEF; wr_be = 2'b11;
    rd_en = 2'b01; rd_addr[3:0] = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    check("byp_full_on", {16'd0, dout1[15:0]}, 32'h0000BEEF);
    tick();
    check("byp_full_off", {16'd0, dout2[15:0]}, 32'h00001111);
    wr(4'd7, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd7; data_in = 16'hBEEF; wr_be = 2'b01;
    rd_en = 2'b01; rd_addr[3:0] = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    check("byp_lo_on", {16'd0, dout1[15:0]}, 32'h000011EF);
    tick();
    check("byp_lo_off", {16'd0, dout2[15:0]}, 32'h00001111);

    for (int i = 0; i < 6; i++) wr(4'(i), 16'h5A00 + 16'(i), 2'b11);
    vc = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) begin
        rd_en   = 2'b11;
        rd_addr = {4'(5 - k), 4'(k)};
      end else rd_en = 2'b00;
      tick();
      if (vld2 == 2'b11) vc++;
      if (k == 0) check("lat2_early", {30'd0, vld2}, 32'd0);
      if (k == 1) check("lat2_first", dout2, {16'h5A05, 16'h5A00});
      if (k == 6) check("lat2_last",  dout2, {16'h5A00, 16'h5A05});
    end
    check("lat2_run", vc, 6);

    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0; bad = 0;
    while (busy1 && n < 100) begin
      n++;
      wr_en = 1'b1; wr_addr = 4'(n); data_in = 16'hABCD; wr_be = 2'b11;
      rd_en = 2'b11; rd_addr = 8'h52;
      tick();
      if (vld1 != 2'b00 || vld2 != 2'b00) bad++;
    end
    wr_en = 1'b0; rd_en = 2'b00;
    check("clr_len_req", n, 16);
    check("clr_no_valid", bad, 0);
    rd0(4'd2, 16'h0000, 16'h0000, "clr_a2");
    read_all();

    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_clear(n);
    check("clr_len_restart", n, 16);
    rd0(4'd12, 16'h0000, 16'h0000, "restart_a12");
    read_all();

    for (int c = 0; c < 600; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom);
      wr_be   = 2'($urandom);
      data_in = 16'($urandom);
      rd_en   = 2'($urandom);
      rd_addr = 8'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      reset   = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1; clr_req = 1'b0; wr_en = 1'b0; rd_en = 2'b00;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
